// File: rtl/eth_ipg_rx_unpack.sv
// eth_ipg_rx_unpack: packs per-cycle PHY IPG bytes into 64-bit AXI-Stream messages through a FWFT FIFO.
// Overflow truncates or drops whole messages; losses are counted in drop_count.
module eth_ipg_rx_unpack #(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH/8,
    parameter int LEN_WIDTH      = 6,
    parameter int FIFO_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     rx_ipg_data,
    input  logic [LEN_WIDTH-1:0]      rx_len,
    input  logic                      rx_block_lock,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      bad_len,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(KEEP_WIDTH + 1);
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t                    st_q, st_d;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d, merged;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW:0]               sum;
    logic [DATA_WIDTH-1:0]     din, w_data;
    logic [KEEP_WIDTH-1:0]     w_keep;
    logic                      w_last, w_user, push, pop, ovf, bad, data_cyc, bad_q;
    logic [AW-1:0]             rd_q, wr_q;
    logic [AW:0]               fcnt_q, free;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];

    assign bad      = rx_len > LEN_WIDTH'(KEEP_WIDTH);
    assign data_cyc = rx_block_lock && rx_len != '0 && !bad;
    assign m_axis_tvalid = fcnt_q != '0;
    assign pop      = m_axis_tvalid && m_axis_tready;
    // space freed by a same-edge pop is usable by this edge's push
    assign free     = (AW+1)'(FIFO_DEPTH) - fcnt_q + (AW+1)'(pop);
    assign sum      = (CW+1)'(cnt_q) + (CW+1)'(rx_len);
    assign merged   = acc_q | ({{DATA_WIDTH{1'b0}}, din} << {cnt_q, 3'b000});

    always_comb begin
        din = '0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            if (i < int'(rx_len)) din[8*i +: 8] = rx_ipg_data[8*i +: 8];
    end

    always_comb begin
        st_d   = st_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        push   = 1'b0;
        ovf    = 1'b0;
        w_data = merged[DATA_WIDTH-1:0];
        w_keep = '1;
        w_last = 1'b0;
        w_user = 1'b0;
        if (st_q == DROP) begin
            st_d = data_cyc ? DROP : IDLE;
        end else if (data_cyc) begin
            st_d = RUN;
            if (sum > (CW+1)'(KEEP_WIDTH)) begin
                if (free >= (AW+1)'(2)) begin
                    push  = 1'b1;
                    acc_d = merged >> DATA_WIDTH;
                    cnt_d = CW'(sum - (CW+1)'(KEEP_WIDTH));
                end else begin
                    // last free slot closes the message as truncated; none left drops it
                    push   = free == (AW+1)'(1);
                    w_last = 1'b1;
                    w_user = 1'b1;
                    ovf    = 1'b1;
                    st_d   = DROP;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end else begin
                acc_d = merged;
                cnt_d = sum[CW-1:0];
            end
        end else begin
            st_d = IDLE;
            if (cnt_q != '0) begin
                w_data = acc_q[DATA_WIDTH-1:0];
                w_keep = {KEEP_WIDTH{1'b1}} >> (CW'(KEEP_WIDTH) - cnt_q);
                w_last = 1'b1;
                w_user = !rx_block_lock || bad;
                push   = free != '0;
                ovf    = free == '0;
                acc_d  = '0;
                cnt_d  = '0;
            end
        end
        drop_d = (ovf && drop_q != '1) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            acc_q  <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
            bad_q  <= 1'b0;
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            bad_q  <= bad;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= {w_user, w_last, w_keep, w_data};

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? mem_q[rd_q] : '0;
    assign bad_len    = bad_q;
    assign drop_count = drop_q;
endmodule

// File: doc/eth_ipg_rx_unpack.md
Name: eth_ipg_rx_unpack

Overview:
- Sits directly downstream of eth_phy_10g_rx and consumes its IPG side channel: rx_ipg_data, rx_len and rx_block_lock.
- Packs the variable number of IPG bytes recovered each cycle into dense 64-bit words, one "IPG message" per contiguous run of non-empty cycles.
- Delivers messages on an AXI-Stream master through a small FIFO.
- The PHY cannot be stalled, so the block handles overflow by truncating or dropping messages and counting them.

Parameters:
- DATA_WIDTH, 64, width of rx_ipg_data and m_axis_tdata (fixed at 64).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- LEN_WIDTH, 6, width of rx_len.
- FIFO_DEPTH, 8, output FIFO depth in words; power of 2, minimum 4.
- DROP_CNT_WIDTH, 16, width of drop_count.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_ipg_data  in  DATA_WIDTH  IPG bytes from the PHY; byte i = bits [8i+7:8i]; the low rx_len bytes are valid.
- rx_len  in  LEN_WIDTH  count of valid bytes this cycle; legal range 0..8.
- rx_block_lock  in  1  PHY block lock.
- m_axis_tdata  out  DATA_WIDTH  packed message data.
- m_axis_tkeep  out  KEEP_WIDTH  contiguous low-order byte mask.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of a message.
- m_axis_tuser  out  1  message truncated or aborted (valid with tlast).
- bad_len  out  1  one-cycle pulse when rx_len > 8.
- drop_count  out  DROP_CNT_WIDTH  saturating count of truncated or dropped messages.

Behaviour:
- Reset: rst_n low at a clk edge sets:
  - state IDLE, accumulator count 0, FIFO empty;
  - m_axis_tvalid 0, tdata/tkeep/tlast/tuser 0;
  - bad_len 0, drop_count 0.
  - Reset mid-message discards all partial and queued data; no tlast is emitted for it.
- Cycle classification:
  - data cycle: rx_block_lock=1 and 1<=rx_len<=8;
  - end cycle: rx_len=0, or rx_block_lock=0, or rx_len>8.
  - rx_len>8 also pulses bad_len for one cycle and ignores that cycle's data.
- Accumulator: 128-bit register plus acc_cnt (0..8 at cycle start).
  - A data cycle appends the low rx_len bytes at byte offset acc_cnt.
  - If acc_cnt+rx_len > 8: push the low 8 bytes (keep=0xFF, last=0), shift the remainder down, acc_cnt = acc_cnt+rx_len-8 (range 1..8).
  - Otherwise acc_cnt = acc_cnt+rx_len; no push.
  - A word is never pushed at exactly 8 bytes, so the final word of a message always carries tlast. At most one push per cycle.
- End cycle with acc_cnt>0 in RUN:
  - push acc with keep=(1<<acc_cnt)-1, last=1;
  - user=1 if the end was caused by lock loss or bad length, else 0;
  - acc_cnt=0, go to IDLE.
  - End cycles in IDLE do nothing.
- FSM:
  - IDLE: go to RUN on a data cycle.
  - RUN: go to IDLE on an end cycle.
  - DROP: discard all data; go to IDLE on an end cycle without pushing.
- FIFO reservation, applied at every push:
  - Non-last push with >=2 free entries: normal push.
  - Non-last push with exactly 1 free entry: push the word with last=1, user=1; drop_count+1; go to DROP.
  - Any push with 0 free entries: no write; drop_count+1; go to DROP. Reservation guarantees this only happens on a message's first push, so no message is left unterminated.
  - drop_count saturates at all-ones.
- FIFO: first-word-fall-through.
  - A word written at edge N is visible with tvalid=1 after edge N.
  - A pop occurs on tvalid&&tready. Simultaneous push and pop are allowed, including when the FIFO is full (pop frees space for the same-edge push; free count is evaluated after the pop).
  - The AXI-S rule holds: once tvalid is asserted, tdata/tkeep/tlast/tuser stay stable until accepted.
- Latency: the last byte of a message arrives in cycle N; the end cycle is N+1; tlast is visible at m_axis from cycle N+2 if the FIFO was empty.

Test Plan:
- rx_len=3 data 0x..CCBBAA, then rx_len=3 data 0x..FFEEDD, then rx_len=0; tready=1 -> single beat tdata=0x0000FFEEDDCCBBAA, tkeep=0x3F, tlast=1, tuser=0.
- Eight cycles of rx_len=8 (bytes 0x00..0x3F ascending), then rx_len=0 -> 8 beats, all tkeep=0xFF; tlast only on beat 8 (0x3F3E3D3C3B3A3938); tuser=0.
- FIFO_DEPTH=4, tready=0, six cycles of rx_len=8 then rx_len=0 -> 4 words queued, 4th has tlast=1, tuser=1, drop_count=1. A second run while full -> no words, drop_count=2. Then release tready -> exactly 4 beats out.
- rx_len=5 then rx_len=9 -> bad_len high for one cycle; one beat tkeep=0x1F, tlast=1, tuser=1.
- rx_len=6, then rx_block_lock=0 with rx_len=4 -> one beat tkeep=0x3F, tlast=1, tuser=1; the lock-loss bytes are absent.
- Mid-run (acc_cnt=5, 2 words queued), assert rst_n=0 for one edge -> tvalid=0, drop_count=0. A following rx_len=2 run yields tkeep=0x03 with no stale bytes.
